decode_out_pipe_buf: RTL

//  Parametrised decode->execute pipeline buffer. Queues decoded bundles
//  {IR, E_control, npc_out, Mem_Control, W_Control} in a DEPTH-entry FIFO.
//  A valid/ready handshake replaces the fixed one-cycle decode_out register.

---
 rtl/decode_out_pipe_buf.sv | 124 ++++++++++++
 1 files changed

// File: rtl/decode_out_pipe_buf.sv
// Decode->execute pipeline buffer: DEPTH-entry FIFO of decoded bundles with valid/ready on both sides.
// Latency 1 cycle (0 with DECODE_OUT_BYPASS_EN when empty); in_ready = not full, independent of out_ready.
// Optional feature macro: DECODE_OUT_BYPASS_EN (empty-buffer combinational pass-through).
module decode_out_pipe_buf #(
    parameter int IR_W    = 16,
    parameter int NPC_W   = 16,
    parameter int ECTRL_W = 6,
    parameter int WCTRL_W = 2,
    parameter int DEPTH   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IR_W-1:0]            IR_in,
    input  logic [ECTRL_W-1:0]         E_control_in,
    input  logic [NPC_W-1:0]           npc_in,
    input  logic                       Mem_Control_in,
    input  logic [WCTRL_W-1:0]         W_Control_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IR_W-1:0]            IR,
    output logic [ECTRL_W-1:0]         E_control,
    output logic [NPC_W-1:0]           npc_out,
    output logic                       Mem_Control,
    output logic [WCTRL_W-1:0]         W_Control,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IR_W-1:0]    ir;
        logic [ECTRL_W-1:0] e_ctrl;
        logic [NPC_W-1:0]   npc;
        logic               mem_ctrl;
        logic [WCTRL_W-1:0] w_ctrl;
    } bundle_t;

    bundle_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    bundle_t            w_in_bundle;
    bundle_t            w_out_bundle;
    logic               w_in_ready;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;

    assign w_in_bundle = '{ir: IR_in, e_ctrl: E_control_in, npc: npc_in,
                           mem_ctrl: Mem_Control_in, w_ctrl: W_Control_in};

    assign w_not_empty = (r_count != '0);
    assign w_in_ready  = reset && (r_count < CNT_W'(DEPTH));

`ifdef DECODE_OUT_BYPASS_EN
    // An empty buffer with a consumer ready hands the bundle straight through without storing it.
    assign w_bypass = reset && !flush && !w_not_empty && in_valid && out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = in_valid && w_in_ready && !w_bypass;
    assign w_pop  = w_not_empty && out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: the output mux never exposes an entry outside the valid window.
    always_ff @(posedge clock) begin
        if (reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= w_in_bundle;
        end
    end

    always_comb begin
        w_out_bundle = '0;
        out_valid    = 1'b0;
        if (reset) begin
            if (w_bypass) begin
                w_out_bundle = w_in_bundle;
                out_valid    = 1'b1;
            end else if (w_not_empty) begin
                w_out_bundle = r_mem[r_rd_ptr];
                out_valid    = 1'b1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign IR          = w_out_bundle.ir;
    assign E_control   = w_out_bundle.e_ctrl;
    assign npc_out     = w_out_bundle.npc;
    assign Mem_Control = w_out_bundle.mem_ctrl;
    assign W_Control   = w_out_bundle.w_ctrl;
    assign count       = r_count;

endmodule
